// File: rtl/adma_wr_arb.sv
// rtl/adma_wr_arb.sv - merges per-channel AXI4 write ports onto one master port.
// Optional B-path skid buffer: define ADMA_WR_ARB_B_PIPE_EN.
module adma_wr_arb #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int MST_ID_W         = 5,
  parameter int CHN_IDX_W        = $clog2(DMA_CHN_NUM),
  parameter int DST_ADDR_W       = 32,
  parameter int DMA_DST_DATA_W   = 256,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int TRANS_RESP_W     = 2,
  parameter int WORD_FIFO_DEPTH  = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [MST_ID_W-1:0]                   s_awid_i    [0:DMA_CHN_NUM-1],
  input  logic [DST_ADDR_W-1:0]                 s_awaddr_i  [0:DMA_CHN_NUM-1],
  input  logic [TRANS_DATA_LEN_W-1:0]           s_awlen_i   [0:DMA_CHN_NUM-1],
  input  logic [1:0]                            s_awburst_i [0:DMA_CHN_NUM-1],
  input  logic [DMA_CHN_NUM-1:0]                s_awvalid_i,
  output logic [DMA_CHN_NUM-1:0]                s_awready_o,
  input  logic [DMA_DST_DATA_W-1:0]             s_wdata_i   [0:DMA_CHN_NUM-1],
  input  logic [DMA_CHN_NUM-1:0]                s_wlast_i,
  input  logic [DMA_CHN_NUM-1:0]                s_wvalid_i,
  output logic [DMA_CHN_NUM-1:0]                s_wready_o,
  output logic [MST_ID_W-1:0]                   s_bid_o     [0:DMA_CHN_NUM-1],
  output logic [TRANS_RESP_W-1:0]               s_bresp_o   [0:DMA_CHN_NUM-1],
  output logic [DMA_CHN_NUM-1:0]                s_bvalid_o,
  input  logic [DMA_CHN_NUM-1:0]                s_bready_i,
  output logic [MST_ID_W+CHN_IDX_W-1:0]         m_awid_o,
  output logic [DST_ADDR_W-1:0]                 m_awaddr_o,
  output logic [TRANS_DATA_LEN_W-1:0]           m_awlen_o,
  output logic [1:0]                            m_awburst_o,
  output logic                                  m_awvalid_o,
  input  logic                                  m_awready_i,
  output logic [DMA_DST_DATA_W-1:0]             m_wdata_o,
  output logic                                  m_wlast_o,
  output logic                                  m_wvalid_o,
  input  logic                                  m_wready_i,
  input  logic [MST_ID_W+CHN_IDX_W-1:0]         m_bid_i,
  input  logic [TRANS_RESP_W-1:0]               m_bresp_i,
  input  logic                                  m_bvalid_i,
  output logic                                  m_bready_o
);

  localparam int BID_W = MST_ID_W + CHN_IDX_W;
  localparam int PTR_W = $clog2(WORD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(WORD_FIFO_DEPTH);
  localparam logic [CHN_IDX_W-1:0] LAST_CHN = CHN_IDX_W'(DMA_CHN_NUM - 1);

  logic [CHN_IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                        aw_vld_q, aw_vld_d;
  logic [BID_W-1:0]            aw_id_q;
  logic [DST_ADDR_W-1:0]       aw_addr_q;
  logic [TRANS_DATA_LEN_W-1:0] aw_len_q;
  logic [1:0]                  aw_burst_q;
  logic [CHN_IDX_W-1:0]        gnt_fifo_q [WORD_FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        gnt_found, aw_load, fifo_empty, w_pop;
  logic [CHN_IDX_W-1:0]        gnt_idx, w_head;
  int                          srch_idx;

  // First requester at or after rr_ptr_q, wrapping modulo the channel count.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    srch_idx  = 0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      srch_idx = (int'(rr_ptr_q) + i) % DMA_CHN_NUM;
      if (!gnt_found && s_awvalid_i[srch_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CHN_IDX_W'(srch_idx);
      end
    end
  end

  assign aw_load  = gnt_found & (!aw_vld_q | m_awready_i) & (cnt_q < DEPTH_C);
  assign aw_vld_d = aw_load | (aw_vld_q & !m_awready_i);
  assign rr_ptr_d = (gnt_idx == LAST_CHN) ? '0 : gnt_idx + 1'b1;

  assign fifo_empty = (cnt_q == '0);
  assign w_head     = gnt_fifo_q[rd_ptr_q];
  assign m_wvalid_o = !fifo_empty & s_wvalid_i[w_head];
  assign m_wdata_o  = s_wdata_i[w_head];
  assign m_wlast_o  = s_wlast_i[w_head];
  assign w_pop      = m_wvalid_o & m_wready_i & m_wlast_o;
  assign cnt_d      = cnt_q + CNT_W'(aw_load) - CNT_W'(w_pop);

  always_comb begin
    s_awready_o = '0;
    s_wready_o  = '0;
    if (aw_load && !aresetn) s_awready_o[gnt_idx] = 1'b1;
    if (!fifo_empty && m_wready_i) s_wready_o[w_head] = 1'b1;
  end

  assign m_awvalid_o = aw_vld_q;
  assign m_awid_o    = aw_id_q;
  assign m_awaddr_o  = aw_addr_q;
  assign m_awlen_o   = aw_len_q;
  assign m_awburst_o = aw_burst_q;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      rr_ptr_q   <= '0;
      aw_vld_q   <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < WORD_FIFO_DEPTH; i++) gnt_fifo_q[i] <= '0;
    end else begin
      aw_vld_q <= aw_vld_d;
      cnt_q    <= cnt_d;
      if (aw_load) begin
        rr_ptr_q             <= rr_ptr_d;
        aw_id_q              <= {gnt_idx, s_awid_i[gnt_idx]};
        aw_addr_q            <= s_awaddr_i[gnt_idx];
        aw_len_q             <= s_awlen_i[gnt_idx];
        aw_burst_q           <= s_awburst_i[gnt_idx];
        gnt_fifo_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  logic [BID_W-1:0]        b_id;
  logic [TRANS_RESP_W-1:0] b_resp;
  logic                    b_vld, b_rdy, b_chn_ok;
  logic [CHN_IDX_W-1:0]    b_chn;

`ifdef ADMA_WR_ARB_B_PIPE_EN
  logic [BID_W-1:0]        bbuf_id_q   [2];
  logic [TRANS_RESP_W-1:0] bbuf_resp_q [2];
  logic                    bbuf_rd_q, bbuf_wr_q, b_push, b_pop;
  logic [1:0]              bbuf_cnt_q;

  assign b_id       = bbuf_id_q[bbuf_rd_q];
  assign b_resp     = bbuf_resp_q[bbuf_rd_q];
  assign b_vld      = (bbuf_cnt_q != 2'd0);
  assign m_bready_o = (bbuf_cnt_q != 2'd2);
  assign b_push     = m_bvalid_i & m_bready_o;
  assign b_pop      = b_vld & b_rdy;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      bbuf_rd_q  <= 1'b0;
      bbuf_wr_q  <= 1'b0;
      bbuf_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        bbuf_id_q[i]   <= '0;
        bbuf_resp_q[i] <= '0;
      end
    end else begin
      if (b_push) begin
        bbuf_id_q[bbuf_wr_q]   <= m_bid_i;
        bbuf_resp_q[bbuf_wr_q] <= m_bresp_i;
        bbuf_wr_q              <= ~bbuf_wr_q;
      end
      if (b_pop) bbuf_rd_q <= ~bbuf_rd_q;
      bbuf_cnt_q <= bbuf_cnt_q + 2'(b_push) - 2'(b_pop);
    end
  end
`else
  assign b_id       = m_bid_i;
  assign b_resp     = m_bresp_i;
  assign b_vld      = m_bvalid_i;
  assign m_bready_o = b_rdy;
`endif

  // Responses tagged with a nonexistent channel are swallowed.
  assign b_chn    = b_id[BID_W-1:MST_ID_W];
  assign b_chn_ok = (int'(b_chn) < DMA_CHN_NUM);

  always_comb begin
    s_bvalid_o = '0;
    b_rdy      = 1'b1;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      s_bid_o[i]   = b_id[MST_ID_W-1:0];
      s_bresp_o[i] = b_resp;
    end
    if (b_chn_ok) begin
      b_rdy             = s_bready_i[b_chn];
      s_bvalid_o[b_chn] = b_vld & !aresetn;
    end
  end

endmodule

// File: tb/tb_adma_wr_arb.sv
// tb/tb_adma_wr_arb.sv - randomized bench for adma_wr_arb against a queue-based model.
module tb_adma_wr_arb;
  localparam int N = 4, IDW = 5, CW = 2, AW = 32, DW = 256, LW = 8, RW = 2, DEPTH = 4;
  localparam int BW = IDW + CW;

  logic clk = 1'b0;
  logic rst;
  logic [IDW-1:0] s_awid    [0:N-1];
  logic [AW-1:0]  s_awaddr  [0:N-1];
  logic [LW-1:0]  s_awlen   [0:N-1];
  logic [1:0]     s_awburst [0:N-1];
  logic [N-1:0]   s_awvalid, s_awready;
  logic [DW-1:0]  s_wdata   [0:N-1];
  logic [N-1:0]   s_wlast, s_wvalid, s_wready;
  logic [IDW-1:0] s_bid     [0:N-1];
  logic [RW-1:0]  s_bresp   [0:N-1];
  logic [N-1:0]   s_bvalid, s_bready;
  logic [BW-1:0]  m_awid;
  logic [AW-1:0]  m_awaddr;
  logic [LW-1:0]  m_awlen;
  logic [1:0]     m_awburst;
  logic           m_awvalid, m_awready;
  logic [DW-1:0]  m_wdata;
  logic           m_wlast, m_wvalid, m_wready;
  logic [BW-1:0]  m_bid;
  logic [RW-1:0]  m_bresp;
  logic           m_bvalid, m_bready;

  adma_wr_arb dut (
    .aclk(clk), .aresetn(rst),
    .s_awid_i(s_awid), .s_awaddr_i(s_awaddr), .s_awlen_i(s_awlen), .s_awburst_i(s_awburst),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wlast_i(s_wlast), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
    .s_bid_o(s_bid), .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .m_awid_o(m_awid), .m_awaddr_o(m_awaddr), .m_awlen_o(m_awlen), .m_awburst_o(m_awburst),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wlast_o(m_wlast), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bid_i(m_bid), .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: granted-but-unfinished channels in order, AW register, rotation pointer.
  int            gq[$];
  int            rr;
  bit            aw_v;
  logic [BW-1:0] e_id;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_len;
  logic [1:0]    e_burst;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    gq.delete();
    rr   = 0;
    aw_v = 1'b0;
  endtask

  task automatic idle_inputs();
    s_awvalid = '0;
    s_wvalid  = '0;
    s_wlast   = '0;
    s_bready  = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bid     = '0;
    m_bresp   = '0;
    for (int k = 0; k < N; k++) begin
      s_awid[k] = '0; s_awaddr[k] = '0; s_awlen[k] = '0; s_awburst[k] = '0; s_wdata[k] = '0;
    end
  endtask

  task automatic check_and_step();
    int          win, h, c;
    bit          can, e_wv, pop;
    logic [N-1:0] e_awr, e_wr, e_bv;
    can = (!aw_v || m_awready) && (gq.size() < DEPTH);
    win = -1;
    if (can) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr + i) % N;
        if (win < 0 && s_awvalid[k]) win = k;
      end
    end
    e_awr = '0;
    if (win >= 0) e_awr[win] = 1'b1;
    check("aw_ready", s_awready, e_awr);
    check("aw_valid", m_awvalid, aw_v);
    if (aw_v) begin
      check("aw_id", m_awid, e_id);
      check("aw_addr", m_awaddr, e_addr);
      check("aw_len", m_awlen, e_len);
      check("aw_burst", m_awburst, e_burst);
    end

    e_wv = 1'b0;
    e_wr = '0;
    h    = 0;
    if (gq.size() > 0) begin
      h    = gq[0];
      e_wv = s_wvalid[h];
      if (m_wready) e_wr[h] = 1'b1;
    end
    check("w_valid", m_wvalid, e_wv);
    check("w_ready", s_wready, e_wr);
    if (e_wv) begin
      check("w_data", m_wdata, s_wdata[h]);
      check("w_last", m_wlast, s_wlast[h]);
    end
    pop = e_wv && m_wready && s_wlast[h];

    c    = int'(m_bid) / (1 << IDW);
    e_bv = '0;
    if (m_bvalid) e_bv[c] = 1'b1;
    check("b_valid", s_bvalid, e_bv);
    check("b_ready", m_bready, s_bready[c]);
    if (m_bvalid) begin
      check("b_id", s_bid[c], m_bid[IDW-1:0]);
      check("b_resp", s_bresp[c], m_bresp);
    end

    if (pop) void'(gq.pop_front());
    if (win >= 0) begin
      gq.push_back(win);
      aw_v    = 1'b1;
      e_id    = BW'(win * (1 << IDW)) | BW'(s_awid[win]);
      e_addr  = s_awaddr[win];
      e_len   = s_awlen[win];
      e_burst = s_awburst[win];
      rr      = (win + 1) % N;
    end else if (m_awready) begin
      aw_v = 1'b0;
    end
  endtask

  task automatic run(input int cycles, input int p_awv, input int p_awr, input int p_wv,
                     input int p_wr, input int p_last);
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        s_awvalid[k] = ($urandom_range(99) < p_awv);
        s_awid[k]    = IDW'($urandom);
        s_awaddr[k]  = $urandom;
        s_awlen[k]   = LW'($urandom);
        s_awburst[k] = 2'($urandom);
        s_wvalid[k]  = ($urandom_range(99) < p_wv);
        s_wlast[k]   = ($urandom_range(99) < p_last);
        s_wdata[k]   = rand_data();
        s_bready[k]  = $urandom_range(1);
      end
      m_awready = ($urandom_range(99) < p_awr);
      m_wready  = ($urandom_range(99) < p_wr);
      m_bvalid  = $urandom_range(1);
      m_bid     = BW'($urandom);
      m_bresp   = RW'($urandom);
      #3;
      check_and_step();
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_aw_ready"}, s_awready, '0);
    check({pfx, "_aw_valid"}, m_awvalid, 1'b0);
    check({pfx, "_w_valid"}, m_wvalid, 1'b0);
    check({pfx, "_w_ready"}, s_wready, '0);
    check({pfx, "_b_valid"}, s_bvalid, '0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    s_awvalid = '1;
    s_wvalid  = '1;
    m_wready  = 1'b1;
    m_awready = 1'b1;
    m_bvalid  = 1'b1;
    m_bid     = {2'd3, 5'd9};
    s_bready  = '1;
    repeat (2) @(posedge clk);
    #2;
    check_outputs_zero("rst");
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;

    run(16, 100, 100, 100, 100, 100);
    run(10, 100, 100, 0, 100, 100);
    run(12, 100, 100, 100, 100, 60);
    run(8, 100, 0, 50, 50, 50);
    run(400, 50, 70, 60, 70, 30);
    run(12, 100, 100, 100, 100, 0);

    @(posedge clk);
    #1;
    s_awvalid = '1;
    s_wvalid  = '1;
    m_wready  = 1'b1;
    m_awready = 1'b1;
    m_bvalid  = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;

    run(8, 100, 100, 100, 100, 100);
    run(300, 60, 60, 70, 60, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adma_wr_arb.md
# adma_wr_arb

Write-side arbiter sitting directly downstream of the DMA's per-channel AXI4 master write ports. It merges DMA_CHN_NUM independent AW/W/B channel sets onto a single AXI4 master write port toward the interconnect. AW uses round-robin arbitration, and W bursts are ordered by AW grant. Each channel index is tagged into the upper AWID bits so that B responses can be routed back to the issuing channel.

## Interface
- DMA_CHN_NUM, 4: number of upstream write channels (≥2).
- MST_ID_W, 5: upstream ID width.
- CHN_IDX_W, $clog2(DMA_CHN_NUM): channel tag width.
- DST_ADDR_W, 32: address width.
- DMA_DST_DATA_W, 256: write data width.
- TRANS_DATA_LEN_W, 8: AWLEN width.
- TRANS_RESP_W, 2: BRESP width.
- WORD_FIFO_DEPTH, 4: number of granted-but-unfinished W bursts tracked (power of 2).
- aclk  input  1  clock.
- aresetn  input  1  asynchronous, active-high reset (1 = reset), despite the name.
- s_awid_i/s_awaddr_i/s_awlen_i/s_awburst_i  input  MST_ID_W/DST_ADDR_W/TRANS_DATA_LEN_W/2 ×[0:DMA_CHN_NUM-1]  per-channel AW payload.
- s_awvalid_i input, s_awready_o output  1 ×[0:DMA_CHN_NUM-1]  per-channel AW handshake.
- s_wdata_i  input  DMA_DST_DATA_W ×[0:DMA_CHN_NUM-1]  per-channel W data.
- s_wlast_i, s_wvalid_i input, s_wready_o output  1 ×[0:DMA_CHN_NUM-1]  per-channel W control.
- s_bid_o  output  MST_ID_W ×[0:DMA_CHN_NUM-1]  per-channel B ID.
- s_bresp_o  output  TRANS_RESP_W ×[0:DMA_CHN_NUM-1]  per-channel B response.
- s_bvalid_o output, s_bready_i input  1 ×[0:DMA_CHN_NUM-1]  per-channel B handshake.
- m_awid_o  output  MST_ID_W+CHN_IDX_W  {channel index, upstream ID}.
- m_awaddr_o/m_awlen_o/m_awburst_o, m_awvalid_o  output; m_awready_i  input  merged AW channel.
- m_wdata_o, m_wlast_o, m_wvalid_o  output; m_wready_i  input  merged W channel.
- m_bid_i  input  MST_ID_W+CHN_IDX_W  returned ID.
- m_bresp_i, m_bvalid_i  input; m_bready_o  output  merged B channel.

## Operation
- **AW register:**
  - A single output register holds the granted AW.
  - The register may load when it is empty, or when it is draining in the same cycle (m_awvalid_o & m_awready_i).
  - The register may load only when the grant FIFO count < WORD_FIFO_DEPTH. A concurrent pop does not free a slot in the same cycle.
- **AW arbitration:**
  - Round-robin over channels with s_awvalid_i set.
  - Search starts at pointer rr_ptr; the first valid channel k at or after rr_ptr (mod DMA_CHN_NUM) wins.
  - On load: s_awready_o[k]=1 for that cycle only, payload captured, m_awid_o = {k, s_awid_i[k]}, k pushed into the grant FIFO, rr_ptr ← (k+1) mod DMA_CHN_NUM.
  - Wrap from DMA_CHN_NUM-1 to 0.
  - At most one s_awready_o is high per cycle.
- **W routing:**
  - The grant FIFO head h selects the W source, combinationally.
  - m_wvalid_o = !empty & s_wvalid_i[h]; m_wdata_o/m_wlast_o come from channel h.
  - s_wready_o[h] = !empty & m_wready_i; all other s_wready_o are 0.
  - Pop on (m_wvalid_o & m_wready_i & m_wlast_o).
  - W data arriving before its AW is granted is stalled, not forwarded.
- **B routing:**
  - c = m_bid_i[MST_ID_W+CHN_IDX_W-1:MST_ID_W].
  - s_bvalid_o[c] = m_bvalid_i; all other s_bvalid_o are 0.
  - s_bid_o[c] = m_bid_i[MST_ID_W-1:0]; s_bresp_o = m_bresp_i.
  - m_bready_o = s_bready_i[c].
  - If c ≥ DMA_CHN_NUM, the response is accepted (m_bready_o=1) and dropped.
- **Reset** (at any time, including mid-burst):
  - rr_ptr=0, grant FIFO emptied, AW register empty.
  - Outputs go to 0: m_awvalid_o, s_awready_o, m_wvalid_o, s_wready_o, s_bvalid_o.
  - In-flight bursts are abandoned; no recovery.

## Timing
- AW latency: s_awvalid_i[k] to m_awvalid_o is 1 cycle.
- AW throughput: 1 AW per cycle while m_awready_i=1 and the FIFO has space.
- m_aw* is held stable while m_awvalid_o & !m_awready_i.
- W path: 0-cycle combinational; full throughput within a burst; 0 idle cycles between consecutive granted bursts.
- Grant FIFO full (WORD_FIFO_DEPTH granted, unfinished bursts): no s_awready_o until a pop registers, i.e. 1 cycle after the wlast beat.
- Simultaneous AW push and wlast pop: both take effect; the count is unchanged.
- B path: 0-cycle combinational (see Configuration).

## Configuration
- **ADMA_WR_ARB_B_PIPE_EN defined:**
  - B path gets a 2-entry skid buffer, giving +1 cycle latency.
  - m_bready_o = buffer not full; it is 1 out of reset.
  - Routing is applied at the buffer output.
  - Full throughput with s_bready_i held high.
- **ADMA_WR_ARB_B_PIPE_EN undefined:**
  - Combinational B routing as in Operation.
  - m_bready_o follows s_bready_i[c].

## Test plan
- **Arbitration rotation:** s_awvalid_i held high on all 4 channels with m_awready_i=1 → grants 0,1,2,3,0,… one per cycle; m_awid_o[6:5] follows the same sequence.
- **W ordering:** AW on ch2 (len 3) then ch0 (len 0); ch0 W presented first → ch0 stalled until 4 ch2 beats with wlast complete; the ch0 beat follows with no gap.
- **FIFO full:** depth 4, 4 AWs granted with no W → 5th s_awvalid_i sees s_awready_o=0. After one wlast handshake, 5th grant occurs 1 cycle later.
- **B routing:** m_bid_i={2'd3,5'd9}, m_bvalid_i=1 → only s_bvalid_o[3]=1 with s_bid_o[3]=9. s_bready_i[3]=0 → m_bready_o=0 (no macro).
- **Backpressure hold:** m_awready_i=0 for 5 cycles → m_awaddr_o and m_awid_o are stable; no further s_awready_o.
- **Reset mid-burst:** aresetn=1 after 2 of 4 beats → all valids/readies drop asynchronously. After release, the first grant goes to ch0 when all channels request.
